// File: rtl/alu_iter_pkg.sv
// Package for the iterative ALU.
// Holds the opcode constants shared by the ALU, its controller and the
// benches, the FSM state encoding, and a small opcode classification helper.
package alu_iter_pkg;

    // Opcode encodings carried on ALU_sel
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_DIV = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_LSH = 4'd6;
    localparam logic [3:0] ALU_RSH = 4'd7;
    localparam logic [3:0] ALU_NEG = 4'd8;
    localparam logic [3:0] ALU_MOD = 4'd9;
    localparam logic [3:0] ALU_XOR = 4'd10;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for the opcodes served by the restoring divider
    function automatic logic op_is_divmod(input logic [3:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_restoring_div.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first step is folded into the load edge, so the quotient and
// remainder are final WIDTH-1 edges after the start edge (WIDTH steps total).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               load dividend/divisor and perform the first step
//   dividend, divisor   operands sampled when start=1 (divisor must be non-zero)
//   done                quotient/remainder hold the final result
//   quotient, remainder division result
module alu_restoring_div
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, and shift the quotient bit
    // into the vacated LSB of the dividend register.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] trial;
        trial = {rem, quo[WIDTH-1]};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Next-state: load with the first step on start, then step until WIDTH steps are done
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            {rem_d, quo_d} = div_step({WIDTH{1'b0}}, dividend, divisor);
            dvs_d          = divisor;
            cnt_d          = CNT_W'(1);
            run_d          = 1'b1;
        end else if (run_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            cnt_d          = cnt_q + CNT_W'(1);
            run_d          = ((cnt_q + CNT_W'(1)) != CNT_W'(WIDTH));
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done      = !run_q && (cnt_q == CNT_W'(WIDTH));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU for the axis_cpu datapath.
// Single-cycle logic/add/shift ops, iterative DIV/MOD (restoring divider) and
// MUL (shift-add, or single-cycle when ITER_MUL=0), a held result register and
// an ALU_rdy/ALU_vld/ALU_ack handshake. Compare flags are combinational on A/B.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   A, B             operands (captured at accept)
//   ALU_sel          opcode (see alu_iter_pkg)
//   ALU_en           start request, taken when ALU_rdy=1
//   ALU_rdy          a new op can be accepted this cycle
//   ALU_out          result, stable while ALU_vld=1
//   ALU_vld          result valid
//   ALU_ack          consumer takes the result when ALU_vld & ALU_ack
//   div_by_zero      result came from DIV/MOD with B=0
//   set, eq, gt, ge  |(A&B), A==B, A>B, A>=B on the live operands
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITER_MUL   = 1,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_sel,
    input  logic             ALU_en,
    output logic             ALU_rdy,
    output logic [WIDTH-1:0] ALU_out,
    output logic             ALU_vld,
    input  logic             ALU_ack,
    output logic             div_by_zero,
    output logic             set,
    output logic             eq,
    output logic             gt,
    output logic             ge
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t WIDTH_V = word_t'(WIDTH);

    alu_state_e state_q, state_d;

    word_t            out_q, out_d;
    logic             dbz_q, dbz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_mul_q, op_mul_d;
    logic             op_div_q, op_div_d;
    word_t            mul_acc_q, mul_acc_d;
    word_t            mul_a_q, mul_a_d;
    word_t            mul_b_q, mul_b_d;

    logic  accept_s;
    logic  is_divmod_s;
    logic  is_mul_s;
    logic  b_zero_s;
    logic  iter_s;
    logic  busy_last_s;
    logic  iter_done_s;
    logic  shift_big_s;
    word_t prod_s;
    word_t single_s;
    logic  div_start_s;
    logic  div_done_s;
    word_t div_quo_s;
    word_t div_rem_s;

    assign accept_s    = ALU_en & ALU_rdy;
    assign is_divmod_s = op_is_divmod(ALU_sel);
    assign is_mul_s    = (ALU_sel == ALU_MUL);
    assign b_zero_s    = (B == '0);
    // Divide-by-zero short-circuits to a single-cycle result
    assign iter_s      = (is_divmod_s & !b_zero_s) | (is_mul_s & (ITER_MUL != 0));
    assign div_start_s = accept_s & is_divmod_s & !b_zero_s;
    assign busy_last_s = (cnt_q == CNT_W'(WIDTH - 1));
    // The divider finishes on the same cycle the counter reaches WIDTH-1
    assign iter_done_s = busy_last_s & (op_mul_q | div_done_s);
    assign shift_big_s = (B >= WIDTH_V);
    assign prod_s      = A * B;

    alu_restoring_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (A),
        .divisor  (B),
        .done     (div_done_s),
        .quotient (div_quo_s),
        .remainder(div_rem_s)
    );

    // Single-cycle result mux on the live operands
    always_comb begin
        single_s = '0;
        case (ALU_sel)
            ALU_ADD: single_s = A + B;
            ALU_SUB: single_s = A - B;
            ALU_MUL: single_s = (ITER_MUL != 0) ? '0 : prod_s;
            ALU_DIV: single_s = '0;
            ALU_MOD: single_s = '0;
            ALU_OR:  single_s = A | B;
            ALU_AND: single_s = A & B;
            ALU_LSH: single_s = shift_big_s ? '0 : (A << B[SH_W-1:0]);
            ALU_RSH: single_s = shift_big_s ? '0 : (A >> B[SH_W-1:0]);
            ALU_NEG: single_s = '0 - A;
            ALU_XOR: single_s = A ^ B;
            default: single_s = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = iter_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_d = iter_s ? ST_BUSY : ST_DONE;
                end else if (ALU_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready for a new op and result-valid
    always_comb begin
        ALU_rdy = 1'b0;
        ALU_vld = 1'b0;
        case (state_q)
            ST_IDLE: ALU_rdy = !rst;
            ST_BUSY: ALU_rdy = 1'b0;
            ST_DONE: begin
                ALU_rdy = !rst & ALU_ack;
                ALU_vld = 1'b1;
            end
            default: ALU_rdy = 1'b0;
        endcase
    end

    // Datapath next-state: result capture, iteration counter, shift-add multiplier
    always_comb begin
        out_d     = out_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        op_mul_d  = op_mul_q;
        op_div_d  = op_div_q;
        mul_acc_d = mul_acc_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        if (accept_s) begin
            op_mul_d  = is_mul_s;
            op_div_d  = (ALU_sel == ALU_DIV);
            cnt_d     = '0;
            // First multiplier bit is consumed at accept, like the divider's first step
            mul_acc_d = B[0] ? A : '0;
            mul_a_d   = {A[WIDTH-2:0], 1'b0};
            mul_b_d   = {1'b0, B[WIDTH-1:1]};
            if (!iter_s) begin
                out_d = single_s;
                dbz_d = is_divmod_s & b_zero_s;
            end else begin
                out_d = out_q;
            end
        end else if (state_q == ST_BUSY) begin
            cnt_d     = cnt_q + CNT_W'(1);
            mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
            mul_a_d   = {mul_a_q[WIDTH-2:0], 1'b0};
            mul_b_d   = {1'b0, mul_b_q[WIDTH-1:1]};
            if (iter_done_s) begin
                out_d = op_mul_q ? mul_acc_q : (op_div_q ? div_quo_s : div_rem_s);
                dbz_d = 1'b0;
            end else begin
                out_d = out_q;
            end
        end else begin
            out_d = out_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            op_mul_q  <= 1'b0;
            op_div_q  <= 1'b0;
            mul_acc_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            out_q     <= out_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
            op_mul_q  <= op_mul_d;
            op_div_q  <= op_div_d;
            mul_acc_q <= mul_acc_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    assign ALU_out     = out_q;
    assign div_by_zero = dbz_q;

    // Branch flags on the live operands
    assign set = |(A & B);
    assign eq  = (A == B);
    assign gt  = (SIGNED_CMP != 0) ? ($signed(A) >  $signed(B)) : (A >  B);
    assign ge  = (SIGNED_CMP != 0) ? ($signed(A) >= $signed(B)) : (A >= B);

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: dut1 is WIDTH=32, ITER_MUL=1, unsigned compare;
// dut2 is WIDTH=32, ITER_MUL=0, signed compare, sharing clk/rst/A/B.
module tb_alu_iter;
    import alu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [3:0]  sel1, sel2;
    logic        en1, en2, ack1, ack2;
    logic        rdy1, vld1, dbz1, set1, eq1, gt1, ge1;
    logic        rdy2, vld2, dbz2, set2, eq2, gt2, ge2;
    logic [31:0] out1, out2;

    int n_cmp = 0;
    int n_bad = 0;

    alu_iter #(.WIDTH(32), .ITER_MUL(1), .SIGNED_CMP(0)) dut1 (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALU_sel(sel1), .ALU_en(en1),
        .ALU_rdy(rdy1), .ALU_out(out1), .ALU_vld(vld1), .ALU_ack(ack1),
        .div_by_zero(dbz1), .set(set1), .eq(eq1), .gt(gt1), .ge(ge1)
    );

    alu_iter #(.WIDTH(32), .ITER_MUL(0), .SIGNED_CMP(1)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALU_sel(sel2), .ALU_en(en2),
        .ALU_rdy(rdy2), .ALU_out(out2), .ALU_vld(vld2), .ALU_ack(ack2),
        .div_by_zero(dbz2), .set(set2), .eq(eq2), .gt(gt2), .ge(ge2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy1); end
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", vld1); end
        n_cmp++; if (out1 !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out1); end
        n_cmp++; if (dbz1 !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", dbz1); end
        rst = 1'b0;
        #1;
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_after: got %b want 1", rdy1); end
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy2_after: got %b want 1", rdy2); end
    endtask

    task automatic test_single();
        logic [3:0]  ops [7] = '{ALU_ADD, ALU_LSH, ALU_SUB, ALU_LSH, ALU_RSH, ALU_NEG, 4'd13};
        logic [31:0] av  [7] = '{32'd7, 32'd1, 32'd3, 32'd1, 32'h80000000, 32'd1, 32'd5};
        logic [31:0] bv  [7] = '{32'd5, 32'd40, 32'd5, 32'd31, 32'd32, 32'd0, 32'd5};
        logic [31:0] ev  [7] = '{32'd12, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd0};
        ack1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            A = av[i]; B = bv[i]; sel1 = ops[i]; en1 = 1'b1;
            tick();
            en1 = 1'b0;
            n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL single_vld[%0d]: got %b want 1", i, vld1); end
            n_cmp++; if (out1 !== ev[i]) begin n_bad++; $display("FAIL single_out[%0d]: got %h want %h", i, out1, ev[i]); end
            tick();
            n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL single_vld_drop[%0d]: got %b want 0", i, vld1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [6] = '{ALU_ADD, ALU_XOR, ALU_RSH, ALU_OR, ALU_AND, ALU_ADD};
        logic [31:0] av  [6] = '{32'd1, 32'h0000F0F0, 32'h80000000, 32'h100, 32'hFF, 32'hFFFFFFFF};
        logic [31:0] bv  [6] = '{32'd2, 32'h0000FF00, 32'd31, 32'h1, 32'h0F, 32'd1};
        logic [31:0] ev  [6] = '{32'd3, 32'h00000FF0, 32'd1, 32'h101, 32'h0F, 32'd0};
        ack1 = 1'b1;
        A = av[0]; B = bv[0]; sel1 = ops[0]; en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, vld1); end
            n_cmp++; if (out1 !== ev[i]) begin n_bad++; $display("FAIL b2b_out[%0d]: got %h want %h", i, out1, ev[i]); end
            n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy[%0d]: got %b want 1", i, rdy1); end
            if (i < 5) begin
                A = av[i+1]; B = bv[i+1]; sel1 = ops[i+1];
            end else begin
                en1 = 1'b0;
            end
        end
        tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL b2b_vld_end: got %b want 0", vld1); end
    endtask

    task automatic test_div();
        logic [3:0]  ops [4] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD};
        logic [31:0] av  [4] = '{32'd100, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [4] = '{32'd7, 32'd7, 32'h10, 32'h10};
        logic [31:0] ev  [4] = '{32'd14, 32'd2, 32'h0FFFFFFF, 32'hF};
        int   n;
        logic rdy_ok;
        ack1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = av[i]; B = bv[i]; sel1 = ops[i]; en1 = 1'b1;
            tick();
            en1 = 1'b0; A = 32'hDEAD; B = 32'd3; sel1 = ALU_ADD;
            n = 0; rdy_ok = 1'b1;
            while (vld1 !== 1'b1 && n < 40) begin
                if (rdy1 !== 1'b0) rdy_ok = 1'b0;
                n++;
                tick();
            end
            n_cmp++; if (n != 32) begin n_bad++; $display("FAIL div_latency[%0d]: got %0d want 32", i, n); end
            n_cmp++; if (rdy_ok !== 1'b1) begin n_bad++; $display("FAIL div_busy_rdy[%0d]: got %b want 1", i, rdy_ok); end
            n_cmp++; if (out1 !== ev[i]) begin n_bad++; $display("FAIL div_out[%0d]: got %h want %h", i, out1, ev[i]); end
            n_cmp++; if (dbz1 !== 1'b0) begin n_bad++; $display("FAIL div_dbz[%0d]: got %b want 0", i, dbz1); end
            tick();
            n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL div_vld_drop[%0d]: got %b want 0", i, vld1); end
        end
    endtask

    task automatic test_div_zero();
        ack1 = 1'b1;
        A = 32'd5; B = 32'd0; sel1 = ALU_DIV; en1 = 1'b1;
        tick();
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL dz_vld: got %b want 1", vld1); end
        n_cmp++; if (out1 !== 32'd0) begin n_bad++; $display("FAIL dz_out: got %h want 0", out1); end
        n_cmp++; if (dbz1 !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", dbz1); end
        A = 32'd2; B = 32'd3; sel1 = ALU_ADD;
        tick();
        n_cmp++; if (out1 !== 32'd5) begin n_bad++; $display("FAIL dz_next_out: got %h want 5", out1); end
        n_cmp++; if (dbz1 !== 1'b0) begin n_bad++; $display("FAIL dz_next_flag: got %b want 0", dbz1); end
        A = 32'd9; B = 32'd0; sel1 = ALU_MOD;
        tick();
        en1 = 1'b0;
        n_cmp++; if (out1 !== 32'd0) begin n_bad++; $display("FAIL dz_mod_out: got %h want 0", out1); end
        n_cmp++; if (dbz1 !== 1'b1) begin n_bad++; $display("FAIL dz_mod_flag: got %b want 1", dbz1); end
        tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL dz_vld_drop: got %b want 0", vld1); end
    endtask

    task automatic test_mul_hold();
        int n;
        A = 32'd3; B = 32'hFFFFFFFF; sel1 = ALU_MUL; ack1 = 1'b0; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        n = 0;
        while (vld1 !== 1'b1 && n < 40) begin n++; tick(); end
        n_cmp++; if (n != 32) begin n_bad++; $display("FAIL mul_latency: got %0d want 32", n); end
        for (int j = 0; j < 5; j++) begin
            en1 = 1'b1; sel1 = ALU_ADD; A = 32'd1; B = 32'd1;
            #1;
            n_cmp++; if (out1 !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL mul_hold_out[%0d]: got %h want fffffffd", j, out1); end
            n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL mul_hold_vld[%0d]: got %b want 1", j, vld1); end
            n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL mul_hold_rdy[%0d]: got %b want 0", j, rdy1); end
            tick();
        end
        en1 = 1'b0; ack1 = 1'b1;
        n_cmp++; if (out1 !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL mul_ack_out: got %h want fffffffd", out1); end
        tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL mul_ack_vld: got %b want 0", vld1); end
        A = 32'h00010000; B = 32'h00010001; sel1 = ALU_MUL; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        n = 0;
        while (vld1 !== 1'b1 && n < 40) begin n++; tick(); end
        n_cmp++; if (n != 32) begin n_bad++; $display("FAIL mul2_latency: got %0d want 32", n); end
        n_cmp++; if (out1 !== 32'h00010000) begin n_bad++; $display("FAIL mul2_out: got %h want 00010000", out1); end
        tick();
        A = 32'd3; B = 32'hFFFFFFFF; sel2 = ALU_MUL; ack2 = 1'b1; en2 = 1'b1;
        tick();
        en2 = 1'b0;
        n_cmp++; if (vld2 !== 1'b1) begin n_bad++; $display("FAIL mul1c_vld: got %b want 1", vld2); end
        n_cmp++; if (out2 !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL mul1c_out: got %h want fffffffd", out2); end
        tick();
        n_cmp++; if (vld2 !== 1'b0) begin n_bad++; $display("FAIL mul1c_vld_drop: got %b want 0", vld2); end
    endtask

    task automatic test_reset_mid();
        logic stale;
        ack1 = 1'b1;
        A = 32'd100; B = 32'd7; sel1 = ALU_DIV; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        repeat (10) tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL rst_pre_vld: got %b want 0", vld1); end
        rst = 1'b1;
        #1;
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rdy: got %b want 0", rdy1); end
        tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_vld: got %b want 0", vld1); end
        n_cmp++; if (out1 !== 32'd0) begin n_bad++; $display("FAIL rst_mid_out: got %h want 0", out1); end
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rdy_hold: got %b want 0", rdy1); end
        rst = 1'b0;
        #1;
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL rst_mid_rdy_after: got %b want 1", rdy1); end
        stale = 1'b0;
        repeat (40) begin
            if (vld1 !== 1'b0) stale = 1'b1;
            tick();
        end
        n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stale: got %b want 0", stale); end
        A = 32'd1; B = 32'd1; sel1 = ALU_ADD; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL rst_add_vld: got %b want 1", vld1); end
        n_cmp++; if (out1 !== 32'd2) begin n_bad++; $display("FAIL rst_add_out: got %h want 2", out1); end
        tick();
    endtask

    task automatic test_flags();
        logic [31:0] av [4] = '{32'hFFFFFFFF, 32'd9, 32'd1, 32'hF0};
        logic [31:0] bv [4] = '{32'd1, 32'd9, 32'hFFFFFFFF, 32'h0F};
        // {set, eq, gt, ge}
        logic [3:0]  eu [4] = '{4'b1011, 4'b1101, 4'b1000, 4'b0011};
        logic [3:0]  es [4] = '{4'b1000, 4'b1101, 4'b1011, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            A = av[i]; B = bv[i];
            #1;
            n_cmp++; if ({set1, eq1, gt1, ge1} !== eu[i]) begin n_bad++; $display("FAIL flags_unsigned[%0d]: got %b want %b", i, {set1, eq1, gt1, ge1}, eu[i]); end
            n_cmp++; if ({set2, eq2, gt2, ge2} !== es[i]) begin n_bad++; $display("FAIL flags_signed[%0d]: got %b want %b", i, {set2, eq2, gt2, ge2}, es[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; sel1 = ALU_ADD; sel2 = ALU_ADD;
        en1 = 1'b0; en2 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_mul_hold();
        test_reset_mid();
        test_flags();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
